// File: rtl/lead_gain_ramp.sv
// lead_gain_ramp: lead-path gain stage for the carrier/symbol tracking loops.
// Scales a signed loop error by 2^(curGain - SHIFT_OFFSET) with saturation.
// In track mode the exponent is reduced by acqTrackControl. The gain reaches
// that lower exponent one step per RAMP_LEN sample strobes, so entering track
// does not cause a transient in the loop.
// Build option: define LEAD_GAIN_RAMP_EN to enable the gradual ramp. Without
// it, curGain follows the target exponent one clock later with no ramp.
module lead_gain_ramp #(
    parameter int IN_W         = 12,
    parameter int OUT_W        = 40,
    parameter int EXP_W        = 5,
    parameter int CTL_W        = 2,
    parameter int SHIFT_OFFSET = 3,
    parameter int RAMP_LEN     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clkEn,
    input  logic [IN_W-1:0]  error,
    input  logic [CTL_W-1:0] acqTrackControl,
    input  logic             track,
    input  logic [EXP_W-1:0] leadExp,
    output logic [OUT_W-1:0] leadError,
    output logic             leadValid,
    output logic             saturated,
    output logic             ramping,
    output logic [EXP_W-1:0] curGain
);

    // Intermediate width holds the largest left shift of the error exactly.
    localparam int WIDE = IN_W + (1 << EXP_W) + 1;
    localparam int EW   = (WIDE > OUT_W) ? WIDE : OUT_W;
    localparam logic signed [EW-1:0] MAXV = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [EXP_W-1:0]       r_gain;
    logic [OUT_W-1:0]       r_lead;
    logic                   r_valid;
    logic                   r_sat;

    logic signed [EXP_W:0]  w_diff;
    logic [EXP_W-1:0]       w_target;
    logic signed [EW-1:0]   w_ext;
    logic signed [EW-1:0]   w_shf;
    logic [OUT_W-1:0]       w_lead_nxt;
    logic                   w_sat_nxt;
    int                     w_sh;

    assign w_diff = $signed({1'b0, leadExp})
                  - $signed({{(EXP_W+1-CTL_W){1'b0}}, acqTrackControl});

    // Target exponent. An underflowing track reduction clamps to 1, not 0.
    always_comb begin
        w_target = leadExp;
        if (track) begin
            if (w_diff[EXP_W])
                w_target = EXP_W'(1);
            else
                w_target = w_diff[EXP_W-1:0];
        end
    end

    // Scale by the current exponent, then clamp to the output range.
    always_comb begin
        w_ext      = {{(EW-IN_W){error[IN_W-1]}}, error};
        w_sh       = int'(r_gain) - SHIFT_OFFSET;
        w_shf      = '0;
        if (r_gain != '0) begin
            if (w_sh >= 0)
                w_shf = w_ext <<< w_sh;
            else
                w_shf = w_ext >>> (-w_sh);
        end
        w_sat_nxt  = 1'b0;
        w_lead_nxt = w_shf[OUT_W-1:0];
        if (w_shf > MAXV) begin
            w_lead_nxt = MAXV[OUT_W-1:0];
            w_sat_nxt  = 1'b1;
        end else if (w_shf < MINV) begin
            w_lead_nxt = MINV[OUT_W-1:0];
            w_sat_nxt  = 1'b1;
        end
    end

    // Output register: captures the scaled sample on each strobe and holds between strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lead  <= '0;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_valid <= clkEn;
            if (clkEn) begin
                r_lead <= w_lead_nxt;
                r_sat  <= w_sat_nxt;
            end
        end
    end

`ifdef LEAD_GAIN_RAMP_EN
    localparam logic SETTLED = 1'b0;
    localparam logic RAMPING = 1'b1;
    localparam int   CNT_W   = $clog2(RAMP_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(RAMP_LEN - 1);

    logic             r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [EXP_W-1:0] w_gain_dec;

    assign w_gain_dec = r_gain - EXP_W'(1);

    // Gain state machine. Gain increases apply at once; a track-mode decrease
    // steps down one exponent per RAMP_LEN strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SETTLED;
            r_cnt   <= '0;
            r_gain  <= '0;
        end else if (r_state == SETTLED) begin
            if (track && (w_target < r_gain)) begin
                r_state <= RAMPING;
                r_cnt   <= CNT_RELOAD;
            end else begin
                r_gain  <= w_target;
            end
        end else begin
            if (!track || (w_target >= r_gain)) begin
                r_gain  <= w_target;
                r_state <= SETTLED;
                r_cnt   <= '0;
            end else if (clkEn) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end else begin
                    r_gain <= w_gain_dec;
                    r_cnt  <= CNT_RELOAD;
                    if (w_gain_dec == w_target) begin
                        r_state <= SETTLED;
                        r_cnt   <= '0;
                    end
                end
            end
        end
    end

    assign ramping = (r_state == RAMPING);
`else
    // Without the ramp, the gain follows the target one clock later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_gain <= '0;
        else
            r_gain <= w_target;
    end

    assign ramping = 1'b0;
`endif

    assign leadError = r_lead;
    assign leadValid = r_valid;
    assign saturated = r_sat;
    assign curGain   = r_gain;

endmodule

// File: tb/tb_lead_gain_ramp.sv
// Bench for lead_gain_ramp. It drives two instances from the same inputs:
// the default 40-bit output, and a 16-bit output that exercises clamping.
// The model covers both the ramp and no-ramp builds of the design.
module tb_lead_gain_ramp;

    localparam int RLEN = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clkEn;
    logic [11:0] error;
    logic [1:0]  acq;
    logic        track;
    logic [4:0]  leadExp;

    logic [39:0] lead40;
    logic        v40, s40, r40;
    logic [4:0]  g40;
    logic [15:0] lead16;
    logic        v16, s16, r16;
    logic [4:0]  g16;

    int n_chk = 0;
    int n_err = 0;

    lead_gain_ramp #(.RAMP_LEN(RLEN)) u_dut40 (
        .clk(clk), .reset_n(reset_n), .clkEn(clkEn), .error(error),
        .acqTrackControl(acq), .track(track), .leadExp(leadExp),
        .leadError(lead40), .leadValid(v40), .saturated(s40),
        .ramping(r40), .curGain(g40)
    );

    lead_gain_ramp #(.OUT_W(16), .RAMP_LEN(RLEN)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .clkEn(clkEn), .error(error),
        .acqTrackControl(acq), .track(track), .leadExp(leadExp),
        .leadError(lead16), .leadValid(v16), .saturated(s16),
        .ramping(r16), .curGain(g16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model functions written directly from the gain and scaling rules.
    function automatic int tgt_f(input int le, input int ac, input bit tr);
        if (!tr) return le;
        if (le - ac < 0) return 1;
        return le - ac;
    endfunction

    function automatic longint scale_f(input int g, input int e, input int w, output bit sat);
        longint v, d, hi, lo;
        if (g == 0) v = 0;
        else if (g >= 3) v = longint'(e) * (longint'(1) << (g - 3));
        else begin
            d = longint'(1) << (3 - g);
            v = (e >= 0) ? longint'(e) / d : -((longint'(-e) + d - 1) / d);
        end
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        sat = 1'b0;
        if (v > hi) begin v = hi; sat = 1'b1; end
        if (v < lo) begin v = lo; sat = 1'b1; end
        return v;
    endfunction

    int          m_gain, m_g0, m_n;
    bit          m_ramp, m_v, m_s40, m_s16;
    logic [39:0] m_l40;
    logic [15:0] m_l16;

    // Reference model. In ramp mode the gain is max(target, start - strobes/RLEN).
    always @(posedge clk or negedge reset_n) begin : model
        int t, nn, g;
        longint x40, x16;
        bit sa, sb;
        if (!reset_n) begin
            m_gain <= 0; m_g0 <= 0; m_n <= 0; m_ramp <= 0;
            m_v <= 0; m_s40 <= 0; m_s16 <= 0; m_l40 <= '0; m_l16 <= '0;
        end else begin
            t = tgt_f(int'(leadExp), int'(acq), track);
            m_v <= clkEn;
            if (clkEn) begin
                x40 = scale_f(m_gain, int'($signed(error)), 40, sa);
                x16 = scale_f(m_gain, int'($signed(error)), 16, sb);
                m_l40 <= x40[39:0]; m_s40 <= sa;
                m_l16 <= x16[15:0]; m_s16 <= sb;
            end
`ifdef LEAD_GAIN_RAMP_EN
            if (!m_ramp) begin
                if (track && t < m_gain) begin
                    m_ramp <= 1; m_g0 <= m_gain; m_n <= 0;
                end else m_gain <= t;
            end else if (!track || t >= m_gain) begin
                m_gain <= t; m_ramp <= 0;
            end else begin
                nn = m_n + (clkEn ? 1 : 0);
                g  = m_g0 - nn / RLEN;
                if (g < t) g = t;
                m_n <= nn; m_gain <= g;
                if (g == t) m_ramp <= 0;
            end
`else
            m_gain <= t;
            m_ramp <= 0;
`endif
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("lead40", 64'(lead40), 64'(m_l40));
        chk("sat40",  64'(s40),    64'(m_s40));
        chk("valid40", 64'(v40),   64'(m_v));
        chk("gain40", 64'(g40),    64'(m_gain));
        chk("ramp40", 64'(r40),    64'(m_ramp));
        chk("lead16", 64'(lead16), 64'(m_l16));
        chk("sat16",  64'(s16),    64'(m_s16));
        chk("valid16", 64'(v16),   64'(m_v));
        chk("gain16", 64'(g16),    64'(m_gain));
    end

    task automatic drive(input bit en, input logic [11:0] e);
        clkEn = en;
        error = e;
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n = 1'b0; clkEn = 1'b0; error = '0; acq = '0; track = 1'b0; leadExp = '0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        // unity gain, one-cycle valid
        leadExp = 5'd3;
        drive(0, 12'h000); drive(0, 12'h000);
        drive(1, 12'h7FF);
        chk("t1_lead40", 64'(lead40), 64'h7FF);
        chk("t1_valid",  64'(v40), 64'd1);
        chk("t1_lead16", 64'(lead16), 64'h07FF);
        drive(0, 12'h000);
        chk("t1_valid_off", 64'(v40), 64'd0);
        chk("t1_hold", 64'(lead40), 64'h7FF);

        // floor on right shift, then max exponent
        leadExp = 5'd1;
        drive(0, 12'h000);
        drive(1, 12'hFFB);
        chk("t2_floor40", 64'(lead40), 64'hFF_FFFF_FFFE);
        chk("t2_floor16", 64'(lead16), 64'hFFFE);
        leadExp = 5'd31;
        drive(0, 12'h000);
        drive(1, 12'h800);
        chk("t2_max40", 64'(lead40), 64'h80_0000_0000);
        chk("t2_sat40", 64'(s40), 64'd0);
        chk("t2_sat16", 64'(s16), 64'd1);

        // clamping on the narrow instance
        leadExp = 5'd10;
        drive(0, 12'h000);
        drive(1, 12'h400);
        chk("t3_pos16", 64'(lead16), 64'h7FFF);
        chk("t3_psat16", 64'(s16), 64'd1);
        chk("t3_pos40", 64'(lead40), 64'h2_0000);
        drive(1, 12'hC00);
        chk("t3_neg16", 64'(lead16), 64'h8000);
        chk("t3_nsat16", 64'(s16), 64'd1);
        chk("t3_neg40", 64'(lead40), 64'hFF_FFFE_0000);

        // track entry: ramp 12 -> 9
        leadExp = 5'd12; acq = 2'd3;
        drive(0, 12'h000);
        track = 1'b1;
        drive(1, 12'h123);
`ifdef LEAD_GAIN_RAMP_EN
        chk("t4_enter_ramp", 64'(r40), 64'd1);
        chk("t4_enter_gain", 64'(g40), 64'd12);
        repeat (4) drive(1, 12'h123);
        chk("t4_step11", 64'(g40), 64'd11);
        repeat (8) drive(1, 12'h123);
        chk("t4_end_gain", 64'(g40), 64'd9);
        chk("t4_end_ramp", 64'(r40), 64'd0);
`else
        chk("t4_follow_gain", 64'(g40), 64'd9);
        chk("t4_follow_ramp", 64'(r40), 64'd0);
`endif

        // track falls mid-ramp
        track = 1'b0;
        drive(1, 12'h123);
        chk("t5_up_gain", 64'(g40), 64'd12);
        track = 1'b1;
        repeat (5) drive(1, 12'h123);
        track = 1'b0;
        drive(1, 12'h123);
        chk("t5_abort_gain", 64'(g40), 64'd12);
        chk("t5_abort_ramp", 64'(r40), 64'd0);

        // async reset mid-ramp
        track = 1'b1;
        repeat (2) drive(1, 12'h123);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_lead40", 64'(lead40), 64'd0);
        chk("rst_lead16", 64'(lead16), 64'd0);
        chk("rst_valid",  64'(v40), 64'd0);
        chk("rst_gain",   64'(g40), 64'd0);
        chk("rst_ramp",   64'(r40), 64'd0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        drive(0, 12'h000);
        chk("rst_jump_gain", 64'(g40), 64'd9);

        // underflow clamp, then zero exponent
        track = 1'b0; leadExp = 5'd1;
        drive(0, 12'h000);
        track = 1'b1; acq = 2'd3;
        drive(0, 12'h000);
        chk("t6_clamp_gain", 64'(g40), 64'd1);
        chk("t6_clamp_ramp", 64'(r40), 64'd0);
        leadExp = 5'd2; acq = 2'd2;
        repeat (6) drive(1, 12'h000);
        chk("t6_zero_gain", 64'(g40), 64'd0);
        drive(1, 12'h7FF);
        chk("t6_zero_lead40", 64'(lead40), 64'd0);
        chk("t6_zero_lead16", 64'(lead16), 64'd0);

        drive(0, 12'h000);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lead_gain_ramp.md
# lead_gain_ramp

Parametrised lead-path gain stage for the carrier/symbol tracking loops. Scales a signed loop error by a programmable power-of-two exponent, with the exponent reduced by `acqTrackControl` in track mode. When the loop enters track, the gain steps down gradually, one exponent step per programmable dwell, so the narrowing does not cause a transient. Sits between the loop error detector and the loop-filter summer; output feeds the lead/lag adder.

## Interface
- `IN_W`, 12: error input width (signed).
- `OUT_W`, 40: lead output width (signed).
- `EXP_W`, 5: exponent width.
- `CTL_W`, 2: `acqTrackControl` width.
- `SHIFT_OFFSET`, 3: exponent giving unity gain; shift = exponent − SHIFT_OFFSET.
- `RAMP_LEN`, 16: clkEn cycles per ramp step, ≥1; counter width is clog2(RAMP_LEN)+1.

- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `clkEn` in 1: sample strobe.
- `error` in IN_W: signed loop error, valid when clkEn=1.
- `acqTrackControl` in CTL_W: track-mode exponent reduction.
- `track` in 1: 1 selects track mode.
- `leadExp` in EXP_W: base lead exponent.
- `leadError` out OUT_W: signed scaled error.
- `leadValid` out 1: one-cycle pulse, leadError updated.
- `saturated` out 1: last leadError was clipped.
- `ramping` out 1: gain ramp in progress.
- `curGain` out EXP_W: exponent currently applied.

## Operation
- Target exponent, combinational:
  - track=0: target = leadExp.
  - track=1: d = leadExp − acqTrackControl, computed one bit wider.
  - d<0: target = 1. Otherwise target = d, so d=0 gives 0.
- Scaling with g = curGain:
  - g=0: output 0.
  - g≥1: sign-extend error, then arithmetic shift by g−SHIFT_OFFSET. Positive shift is left; negative shift is right, floor rounding.
- Width rule: if the exact result exceeds the OUT_W signed range, clamp to 2^(OUT_W−1)−1 or −2^(OUT_W−1) and set `saturated`. With default parameters clamping never occurs.
- Gain state machine, states SETTLED and RAMPING:
  - SETTLED, target > curGain, or target < curGain with track=0: curGain ← target on the next clk. No clkEn needed.
  - SETTLED, target < curGain with track=1: enter RAMPING, counter ← RAMP_LEN−1.
  - RAMPING, each clkEn:
    - counter≠0: counter decrements.
    - counter=0: curGain ← curGain−1 and counter reloads.
    - If the new curGain equals target, go to SETTLED.
  - RAMPING, target ≥ curGain, or track falls: curGain ← target immediately; go to SETTLED; counter cleared.
  - RAMPING, target drops further: keep ramping toward the new target; dwell timing is unaffected.
- `ramping` = (state==RAMPING).

## Timing
- Reset values: leadError=0, leadValid=0, saturated=0, ramping=0, curGain=0, state SETTLED, counter=0.
- Latency:
  - leadError, saturated and leadValid update 1 clk after the clkEn cycle.
  - The gain used is the curGain value present during that clkEn cycle, before any same-cycle update.
  - Outputs hold between clkEn strobes.
- Ramp timing:
  - A step of N exponents takes N·RAMP_LEN clkEn strobes.
  - The first decrement happens on the RAMP_LEN-th clkEn after RAMPING is entered.
  - clkEn=0 freezes the counter.
- Reset mid-ramp: immediate return to reset values. The next target is taken in SETTLED, so curGain jumps upward to the target.

## Configuration
- `LEAD_GAIN_RAMP_EN` defined: ramp state machine as above.
- `LEAD_GAIN_RAMP_EN` undefined:
  - No RAMPING state and no counter; `ramping` is tied 0.
  - curGain ← target every clk, one-cycle registered follow.
  - Scaling, saturation and outputs are unchanged.

## Test plan
- Default params, track=0, leadExp=3, error=12'h7FF, clkEn pulse → next clk leadError=40'h7FF, leadValid=1 for exactly one cycle.
- leadExp=1, error=−5 (12'hFFB) → leadError=−2 (floor); leadExp=31, error=12'h800 → leadError=40'h80_0000_0000, saturated=0.
- OUT_W=16, leadExp=10, error=12'h400 → leadError=16'h7FFF, saturated=1; error=−1024 → 16'h8000, saturated=1.
- Ramp, RAMP_LEN=4: leadExp=12, settle, then track=1 with acqTrackControl=3, clkEn every cycle.
  - ramping=1; curGain steps 11, 10, 9 every 4 clkEn.
  - After 12 clkEn: curGain=9 and ramping=0.
- Mid-ramp track=0 → curGain=12 on the next clk, ramping=0. Reset_n low mid-ramp → all outputs 0 asynchronously.
- leadExp=1, acqTrackControl=3, track=1 → target 1 (underflow clamp); leadExp=2, acqTrackControl=2 → curGain 0, leadError=0.
- Build without LEAD_GAIN_RAMP_EN: 12→9 step occurs one clk after track rises; ramping stays 0.
